// File: rtl/vector_cache_pkg.sv
// Shared vector cache controller definitions: WDB geometry, the offer type and
// the lowest-set-bit encoder used by the free-list allocators.
package vector_cache_pkg;

    localparam int WDB_BANK_NUM       = 4;
    localparam int DB_ENTRY_NUM       = 16;
    localparam int DB_ENTRY_IDX_WIDTH = $clog2(DB_ENTRY_NUM);

    // Widest free list the shared encoder serves; callers zero-extend into it.
    localparam int FL_MAX_WIDTH     = 64;
    localparam int FL_MAX_IDX_WIDTH = $clog2(FL_MAX_WIDTH);

    typedef struct packed {
        logic [DB_ENTRY_IDX_WIDTH-1:0] idx;
        logic                          vld;
    } wdb_alloc_t;

    function automatic logic [FL_MAX_IDX_WIDTH-1:0] lowest_set_idx(
        input logic [FL_MAX_WIDTH-1:0] vec
    );
        logic [FL_MAX_IDX_WIDTH-1:0] idx;
        idx = '0;
        for (int i = FL_MAX_WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) idx = i[FL_MAX_IDX_WIDTH-1:0];
        end
        return idx;
    endfunction

endpackage

// File: rtl/wdb_bank_alloc.sv
// One WDB bank: free bitmap, free counter, registered lowest-free offer and,
// when WDB_ALLOC_CHK_EN is defined, the sticky release-protocol checker.
module wdb_bank_alloc #(
    parameter int DB_ENTRY_NUM       = 16,
    parameter int DB_ENTRY_IDX_WIDTH = $clog2(DB_ENTRY_NUM)
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic                          alloc_vld,
    output logic [DB_ENTRY_IDX_WIDTH-1:0] alloc_idx,
    input  logic                          alloc_rdy,
    input  logic                          rel_vld,
    input  logic [DB_ENTRY_IDX_WIDTH-1:0] rel_idx,
    output logic [DB_ENTRY_IDX_WIDTH:0]   free_cnt,
    output logic                          alloc_err
);
    import vector_cache_pkg::*;

    localparam logic [DB_ENTRY_IDX_WIDTH:0] FULL_CNT = (DB_ENTRY_IDX_WIDTH+1)'(DB_ENTRY_NUM);
    localparam logic [DB_ENTRY_IDX_WIDTH:0] ONE_CNT  = (DB_ENTRY_IDX_WIDTH+1)'(1);

    logic [DB_ENTRY_NUM-1:0]       bitmap;
    logic [DB_ENTRY_NUM-1:0]       bitmap_next;
    logic [DB_ENTRY_NUM-1:0]       consume_mask;
    logic [DB_ENTRY_NUM-1:0]       rel_mask;
    logic                          consume;
    logic                          rel_ok;
    logic [DB_ENTRY_IDX_WIDTH:0]   cnt_next;
    logic [DB_ENTRY_IDX_WIDTH-1:0] offer_idx;
`ifdef WDB_ALLOC_CHK_EN
    logic                          err_event;
`endif

    // The offer is taken from the post-update bitmap so a just-consumed entry
    // can never be re-offered and a fresh entry is available every cycle.
    always_comb begin
        consume      = alloc_vld & alloc_rdy;
        consume_mask = '0;
        rel_mask     = '0;
        rel_ok       = rel_vld;
`ifdef WDB_ALLOC_CHK_EN
        err_event    = 1'b0;
        if (rel_vld && (bitmap[rel_idx] || (consume && rel_idx == alloc_idx))) begin
            rel_ok    = 1'b0;
            err_event = 1'b1;
        end
        if ((rel_ok && !consume && free_cnt == FULL_CNT) ||
            (consume && !rel_ok && free_cnt == '0)) begin
            err_event = 1'b1;
        end
`endif
        if (consume) consume_mask[alloc_idx] = 1'b1;
        if (rel_ok)  rel_mask[rel_idx]       = 1'b1;
        bitmap_next = (bitmap & ~consume_mask) | rel_mask;

        cnt_next = free_cnt;
        if (rel_ok && !consume)      cnt_next = free_cnt + ONE_CNT;
        else if (!rel_ok && consume) cnt_next = free_cnt - ONE_CNT;

        offer_idx = DB_ENTRY_IDX_WIDTH'(lowest_set_idx(FL_MAX_WIDTH'(bitmap_next)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bitmap    <= '1;
            free_cnt  <= FULL_CNT;
            alloc_vld <= 1'b0;
            alloc_idx <= '0;
        end else begin
            bitmap    <= bitmap_next;
            free_cnt  <= cnt_next;
            alloc_vld <= |bitmap_next;
            if (|bitmap_next) alloc_idx <= offer_idx;
        end
    end

`ifdef WDB_ALLOC_CHK_EN
    always_ff @(posedge clk) begin
        if (rst)            alloc_err <= 1'b0;
        else if (err_event) alloc_err <= 1'b1;
    end
`else
    assign alloc_err = 1'b0;
`endif

endmodule

// File: rtl/wdb_entry_alloc.sv
// WDB entry allocator: one independent free-list bank per write lane.
// Optional release checking is built when WDB_ALLOC_CHK_EN is defined.
module wdb_entry_alloc #(
    parameter int BANK_NUM           = 4,
    parameter int DB_ENTRY_NUM       = 16,
    parameter int DB_ENTRY_IDX_WIDTH = $clog2(DB_ENTRY_NUM)
) (
    input  logic                                          clk,
    input  logic                                          rst,
    output logic [BANK_NUM-1:0]                           alloc_vld,
    output logic [BANK_NUM-1:0][DB_ENTRY_IDX_WIDTH-1:0]   alloc_idx,
    input  logic [BANK_NUM-1:0]                           alloc_rdy,
    input  logic [BANK_NUM-1:0]                           rel_vld,
    input  logic [BANK_NUM-1:0][DB_ENTRY_IDX_WIDTH-1:0]   rel_idx,
    output logic [BANK_NUM-1:0][DB_ENTRY_IDX_WIDTH:0]     free_cnt,
    output logic [BANK_NUM-1:0]                           alloc_err
);

    for (genvar b = 0; b < BANK_NUM; b++) begin : g_bank
        wdb_bank_alloc #(
            .DB_ENTRY_NUM       (DB_ENTRY_NUM),
            .DB_ENTRY_IDX_WIDTH (DB_ENTRY_IDX_WIDTH)
        ) u_bank (
            .clk       (clk),
            .rst       (rst),
            .alloc_vld (alloc_vld[b]),
            .alloc_idx (alloc_idx[b]),
            .alloc_rdy (alloc_rdy[b]),
            .rel_vld   (rel_vld[b]),
            .rel_idx   (rel_idx[b]),
            .free_cnt  (free_cnt[b]),
            .alloc_err (alloc_err[b])
        );
    end

endmodule

// File: tb/tb_wdb_entry_alloc.sv
// Scoreboard bench for wdb_entry_alloc: directed cases followed by random
// alloc/release traffic with a mid-run reset.
module tb_wdb_entry_alloc;
    localparam int NB = 4;
    localparam int NE = 16;
    localparam int IW = 4;

    logic                       clk = 1'b0;
    logic                       rst;
    logic [NB-1:0]              alloc_vld;
    logic [NB-1:0][IW-1:0]      alloc_idx;
    logic [NB-1:0]              alloc_rdy;
    logic [NB-1:0]              rel_vld;
    logic [NB-1:0][IW-1:0]      rel_idx;
    logic [NB-1:0][IW:0]        free_cnt;
    logic [NB-1:0]              alloc_err;

    always #5 clk = ~clk;

    wdb_entry_alloc #(
        .BANK_NUM           (NB),
        .DB_ENTRY_NUM       (NE),
        .DB_ENTRY_IDX_WIDTH (IW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .alloc_vld (alloc_vld),
        .alloc_idx (alloc_idx),
        .alloc_rdy (alloc_rdy),
        .rel_vld   (rel_vld),
        .rel_idx   (rel_idx),
        .free_cnt  (free_cnt),
        .alloc_err (alloc_err)
    );

    typedef struct packed {
        logic [NB-1:0]         vld;
        logic [NB-1:0][IW-1:0] idx;
        logic [NB-1:0][IW:0]   cnt;
        logic [NB-1:0]         err;
    } exp_t;

    exp_t sb[$];

    // Reference model of every bank plus the set of indices currently issued.
    logic [NB-1:0][NE-1:0] mbm;
    logic [NB-1:0]         mvld;
    logic [NB-1:0][IW-1:0] midx;
    int                    mcnt [NB];
    logic [NB-1:0]         merr;
    logic [NB-1:0][NE-1:0] issued;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic logic [IW-1:0] model_lowest(input logic [NE-1:0] v);
        for (int i = 0; i < NE; i++) if (v[i]) return i[IW-1:0];
        return '0;
    endfunction

    // Drives one cycle, advances the model, pushes the expected outputs and
    // compares them once the DUT has registered the cycle.
    task automatic apply_stimulus(input logic r, input logic [NB-1:0] rdy,
                                  input logic [NB-1:0] rv, input logic [NB-1:0][IW-1:0] ri);
        exp_t e;
        exp_t got;
        logic cons, relok;
        rst       = r;
        alloc_rdy = rdy;
        rel_vld   = rv;
        rel_idx   = ri;
        for (int b = 0; b < NB; b++) begin
            if (r) begin
                mbm[b] = '1; mvld[b] = 1'b0; midx[b] = '0; mcnt[b] = NE; merr[b] = 1'b0;
                issued[b] = '0;
            end else begin
                cons  = mvld[b] & rdy[b];
                relok = rv[b];
`ifdef WDB_ALLOC_CHK_EN
                if (rv[b] && (mbm[b][ri[b]] || (cons && ri[b] == midx[b]))) begin
                    relok   = 1'b0;
                    merr[b] = 1'b1;
                end
`endif
                if (relok) issued[b][ri[b]] = 1'b0;
                if (cons) begin
                    check_output($sformatf("reissue[%0d]", b), 32'(issued[b][midx[b]]), 32'd0);
                    issued[b][midx[b]] = 1'b1;
                    mbm[b][midx[b]] = 1'b0;
                    mcnt[b]--;
                end
                if (relok) begin
                    mbm[b][ri[b]] = 1'b1;
                    mcnt[b]++;
                end
                mvld[b] = |mbm[b];
                if (mvld[b]) midx[b] = model_lowest(mbm[b]);
            end
            e.vld[b] = mvld[b];
            e.idx[b] = midx[b];
            e.cnt[b] = (IW+1)'(mcnt[b]);
            e.err[b] = merr[b];
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        for (int b = 0; b < NB; b++) begin
            check_output($sformatf("vld[%0d]", b), 32'(alloc_vld[b]), 32'(got.vld[b]));
            check_output($sformatf("idx[%0d]", b), 32'(alloc_idx[b]), 32'(got.idx[b]));
            check_output($sformatf("cnt[%0d]", b), 32'(free_cnt[b]),  32'(got.cnt[b]));
            check_output($sformatf("err[%0d]", b), 32'(alloc_err[b]), 32'(got.err[b]));
            check_output($sformatf("popcnt[%0d]", b), 32'(free_cnt[b]), 32'($countones(mbm[b])));
        end
    endtask

    task automatic idle_cycle();
        apply_stimulus(1'b0, '0, '0, '0);
    endtask

    task automatic consume_one(input int b);
        logic [NB-1:0] rdy;
        rdy    = '0;
        rdy[b] = 1'b1;
        apply_stimulus(1'b0, rdy, '0, '0);
    endtask

    task automatic release_one(input int b, input logic [IW-1:0] idx, input logic also_consume);
        logic [NB-1:0]         rdy;
        logic [NB-1:0]         rv;
        logic [NB-1:0][IW-1:0] ri;
        rdy = '0; rv = '0; ri = '0;
        rdy[b] = also_consume;
        rv[b]  = 1'b1;
        ri[b]  = idx;
        apply_stimulus(1'b0, rdy, rv, ri);
    endtask

    function automatic logic pick_allocated(input int b, output logic [IW-1:0] idx);
        int start;
        start = $urandom_range(NE - 1);
        idx   = '0;
        for (int k = 0; k < NE; k++) begin
            if (!mbm[b][(start + k) % NE]) begin
                idx = IW'((start + k) % NE);
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    initial begin
        logic [NB-1:0]         rdy;
        logic [NB-1:0]         rv;
        logic [NB-1:0][IW-1:0] ri;
        logic [IW-1:0]         pick;

        alloc_rdy = '0; rel_vld = '0; rel_idx = '0; rst = 1'b1;
        apply_stimulus(1'b1, '0, '0, '0);
        apply_stimulus(1'b1, 4'hF, '0, '0);
        for (int b = 0; b < NB; b++) begin
            check_output("rst_vld", 32'(alloc_vld[b]), 32'd0);
            check_output("rst_cnt", 32'(free_cnt[b]), 32'd16);
        end

        idle_cycle();
        for (int b = 0; b < NB; b++) begin
            check_output("post_rst_vld", 32'(alloc_vld[b]), 32'd1);
            check_output("post_rst_idx", 32'(alloc_idx[b]), 32'd0);
            check_output("post_rst_cnt", 32'(free_cnt[b]), 32'd16);
        end

        for (int i = 0; i < NE; i++) begin
            check_output("drain0_offer", 32'(alloc_idx[0]), 32'(i));
            consume_one(0);
        end
        check_output("drain0_vld", 32'(alloc_vld[0]), 32'd0);
        check_output("drain0_cnt", 32'(free_cnt[0]), 32'd0);
        for (int i = 0; i < 3; i++) consume_one(0);
        check_output("empty_rdy_cnt", 32'(free_cnt[0]), 32'd0);
        check_output("empty_rdy_idx", 32'(alloc_idx[0]), 32'd15);

        for (int i = 0; i < NE; i++) consume_one(2);
        release_one(2, 4'd9, 1'b0);
        check_output("b2_rel_vld", 32'(alloc_vld[2]), 32'd1);
        check_output("b2_rel_idx", 32'(alloc_idx[2]), 32'd9);
        check_output("b2_rel_cnt", 32'(free_cnt[2]), 32'd1);

        for (int i = 0; i < 5; i++) consume_one(1);
        check_output("b1_offer5", 32'(alloc_idx[1]), 32'd5);
        release_one(1, 4'd2, 1'b1);
        check_output("b1_offer2", 32'(alloc_idx[1]), 32'd2);
        check_output("b1_cnt11", 32'(free_cnt[1]), 32'd11);

`ifdef WDB_ALLOC_CHK_EN
        release_one(3, 4'd3, 1'b0);
        check_output("b3_err", 32'(alloc_err[3]), 32'd1);
        check_output("b3_cnt", 32'(free_cnt[3]), 32'd16);
        check_output("b3_others_err", 32'(alloc_err[2:0]), 32'd0);
        idle_cycle();
        check_output("b3_err_sticky", 32'(alloc_err[3]), 32'd1);
`endif

        apply_stimulus(1'b1, '0, '0, '0);
        idle_cycle();

        for (int cyc = 0; cyc < 10000; cyc++) begin
            rdy = '0; rv = '0; ri = '0;
            for (int b = 0; b < NB; b++) begin
                rdy[b] = ($urandom_range(3) != 0);
                if ($urandom_range(1) == 1 && pick_allocated(b, pick)) begin
                    rv[b] = 1'b1;
                    ri[b] = pick;
                end
            end
            apply_stimulus(cyc == 5000, rdy, rv, ri);
            if (cyc == 5000) begin
                for (int b = 0; b < NB; b++) begin
                    check_output("midrst_vld", 32'(alloc_vld[b]), 32'd0);
                    check_output("midrst_cnt", 32'(free_cnt[b]), 32'd16);
                    check_output("midrst_err", 32'(alloc_err[b]), 32'd0);
                end
            end
        end

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
